// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache-side memory arbiter.
// Holds the arbiter state/owner encodings and the default memory geometry.
package cache_mem_pkg;

    localparam int          DEF_MEM_LATENCY     = 4;
    localparam int          DEF_WORDS_PER_BLOCK = 8;
    localparam logic [15:0] BLOCK_MASK          = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        FILL  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/fill_counter.sv
// Issue and return word counters for one block fill.
// Both counters clear together; the return count saturates at a full block.
module fill_counter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CNT_W           = $clog2(WORDS_PER_BLOCK) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             issue_inc,
    input  logic             ret_inc,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [2:0]       ret_idx,
    output logic             issue_last,
    output logic             ret_done
);

    logic [CNT_W-1:0] ret_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else if (clear) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            if (issue_inc) issue_cnt <= issue_cnt + CNT_W'(1);
            if (ret_inc && !ret_done) ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end

    assign issue_last = (issue_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
    assign ret_done   = (ret_cnt == CNT_W'(WORDS_PER_BLOCK));
    assign ret_idx    = 3'(ret_cnt);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Memory-side responder for the I/D cache controllers: arbitrates block fills and
// write-through stores onto one pipelined, fixed-latency, in-order main memory.
module cache_mem_arbiter
    import cache_mem_pkg::*;
#(
    parameter int MEM_LATENCY     = DEF_MEM_LATENCY,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead_I,
    input  logic [ADDR_W-1:0] mem_read_addr_I,
    output logic              MemDataValid_I,
    output logic [DATA_W-1:0] mem_read_data_I,
    output logic [2:0]        mem_word_idx_I,
    input  logic              MemRead_D,
    input  logic [ADDR_W-1:0] mem_read_addr_D,
    input  logic              MemWrite_D,
    input  logic [ADDR_W-1:0] mem_write_addr_D,
    input  logic [DATA_W-1:0] mem_write_data_D,
    output logic              MemDataValid_D,
    output logic [DATA_W-1:0] mem_read_data_D,
    output logic [2:0]        mem_word_idx_D,
    output logic              mem_write_done_D,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output state_t            dbg_state
);

    localparam int                CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
    localparam logic [ADDR_W-1:0] MASK  = ADDR_W'(BLOCK_MASK);

    // Returns must trail issues by at least a cycle, and the word index ports are 3 bits.
    if (MEM_LATENCY < 1 || WORDS_PER_BLOCK > 8 || WORDS_PER_BLOCK < 2) begin : g_bad_params
        $error("cache_mem_arbiter: unsupported MEM_LATENCY/WORDS_PER_BLOCK");
    end

    state_t            state;
    owner_t            owner;
    logic              i_waiting;
    logic [ADDR_W-1:0] base;

    logic [CNT_W-1:0]  issue_cnt;
    logic [2:0]        ret_idx;
    logic              issue_last;
    logic              ret_done;
    logic              ret_inc;
    logic [ADDR_W-1:0] next_off;

    // Returns outside FILL/DRAIN are stale (e.g. after a mid-fill reset) and dropped.
    assign ret_inc   = ((state == FILL) || (state == DRAIN)) && mem_rvalid && !ret_done;
    assign next_off  = ADDR_W'((32'(issue_cnt) + 32'd1) << 1);
    assign dbg_state = state;

    fill_counter #(
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .CNT_W           (CNT_W)
    ) u_fill_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == IDLE),
        .issue_inc  (state == FILL),
        .ret_inc    (ret_inc),
        .issue_cnt  (issue_cnt),
        .ret_idx    (ret_idx),
        .issue_last (issue_last),
        .ret_done   (ret_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            owner            <= OWN_D;
            i_waiting        <= 1'b0;
            base             <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_write_done_D <= 1'b0;
            MemDataValid_I   <= 1'b0;
            MemDataValid_D   <= 1'b0;
            mem_read_data_I  <= '0;
            mem_read_data_D  <= '0;
            mem_word_idx_I   <= '0;
            mem_word_idx_D   <= '0;
        end else begin
            mem_write_done_D <= 1'b0;
            MemDataValid_I   <= 1'b0;
            MemDataValid_D   <= 1'b0;

            if (ret_inc) begin
                if (owner == OWN_I) begin
                    MemDataValid_I  <= 1'b1;
                    mem_read_data_I <= mem_rdata;
                    mem_word_idx_I  <= ret_idx;
                end else begin
                    MemDataValid_D  <= 1'b1;
                    mem_read_data_D <= mem_rdata;
                    mem_word_idx_D  <= ret_idx;
                end
            end

            case (state)
                IDLE: begin
                    if (MemWrite_D) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= mem_write_addr_D;
                        mem_wdata <= mem_write_data_D;
                    end else if (MemRead_D && !(i_waiting && MemRead_I)) begin
                        // I loses once at most: the next contested grant goes to I.
                        state    <= FILL;
                        owner    <= OWN_D;
                        base     <= mem_read_addr_D & MASK;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= mem_read_addr_D & MASK;
                        if (MemRead_I) i_waiting <= 1'b1;
                    end else if (MemRead_I) begin
                        state     <= FILL;
                        owner     <= OWN_I;
                        base      <= mem_read_addr_I & MASK;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= mem_read_addr_I & MASK;
                        i_waiting <= 1'b0;
                    end
                end
                WRITE: begin
                    mem_req          <= 1'b0;
                    mem_we           <= 1'b0;
                    mem_write_done_D <= 1'b1;
                    state            <= DONE;
                end
                FILL: begin
                    if (issue_last) begin
                        mem_req <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        mem_addr <= base + next_off;
                    end
                end
                DRAIN: begin
                    if (ret_done) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: table vectors, mid-fill reset, randomized grants
// against a priority model, and a short-latency / 4-word instance.
module tb_cache_mem_arbiter;
    import cache_mem_pkg::*;

    localparam int LAT      = 4;
    localparam int WPB      = 8;
    localparam int LAT_B    = 1;
    localparam int WPB_B    = 4;
    localparam int K_WRITE  = 0;
    localparam int K_FILL_D = 1;
    localparam int K_FILL_I = 2;

    typedef struct {
        logic        ri;
        logic        rd;
        logic        wd;
        logic [15:0] ai;
        logic [15:0] ad;
        logic [15:0] wa;
        logic [15:0] wdat;
        int          kind;
        logic [15:0] ea;
        logic [15:0] ewd;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A (default parameters) ----------------
    logic        rd_i, rd_d, wr_d;
    logic [15:0] addr_i, addr_d, waddr, wdata;
    logic        dv_i, dv_d, wdone, mreq, mwe, mrvalid;
    logic [15:0] rdata_i, rdata_d, maddr, mwdata, mrdata;
    logic [2:0]  idx_i, idx_d;
    state_t      st_a;

    cache_mem_arbiter u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .MemRead_I        (rd_i),
        .mem_read_addr_I  (addr_i),
        .MemDataValid_I   (dv_i),
        .mem_read_data_I  (rdata_i),
        .mem_word_idx_I   (idx_i),
        .MemRead_D        (rd_d),
        .mem_read_addr_D  (addr_d),
        .MemWrite_D       (wr_d),
        .mem_write_addr_D (waddr),
        .mem_write_data_D (wdata),
        .MemDataValid_D   (dv_d),
        .mem_read_data_D  (rdata_d),
        .mem_word_idx_D   (idx_d),
        .mem_write_done_D (wdone),
        .mem_req          (mreq),
        .mem_we           (mwe),
        .mem_addr         (maddr),
        .mem_wdata        (mwdata),
        .mem_rdata        (mrdata),
        .mem_rvalid       (mrvalid),
        .dbg_state        (st_a)
    );

    // ---------------- DUT B (latency 1, 4-word blocks) ----------------
    logic        rd_i_b, rd_d_b, wr_d_b;
    logic [15:0] addr_i_b, addr_d_b, waddr_b, wdata_b;
    logic        dv_i_b, dv_d_b, wdone_b, mreq_b, mwe_b, mrvalid_b;
    logic [15:0] rdata_i_b, rdata_d_b, maddr_b, mwdata_b, mrdata_b;
    logic [2:0]  idx_i_b, idx_d_b;
    state_t      st_b;

    cache_mem_arbiter #(.MEM_LATENCY(LAT_B), .WORDS_PER_BLOCK(WPB_B)) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .MemRead_I        (rd_i_b),
        .mem_read_addr_I  (addr_i_b),
        .MemDataValid_I   (dv_i_b),
        .mem_read_data_I  (rdata_i_b),
        .mem_word_idx_I   (idx_i_b),
        .MemRead_D        (rd_d_b),
        .mem_read_addr_D  (addr_d_b),
        .MemWrite_D       (wr_d_b),
        .mem_write_addr_D (waddr_b),
        .mem_write_data_D (wdata_b),
        .MemDataValid_D   (dv_d_b),
        .mem_read_data_D  (rdata_d_b),
        .mem_word_idx_D   (idx_d_b),
        .mem_write_done_D (wdone_b),
        .mem_req          (mreq_b),
        .mem_we           (mwe_b),
        .mem_addr         (maddr_b),
        .mem_wdata        (mwdata_b),
        .mem_rdata        (mrdata_b),
        .mem_rvalid       (mrvalid_b),
        .dbg_state        (st_b)
    );

    // ---------------- memory models: in-order, fixed latency ----------------
    function automatic logic [15:0] mem_img(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5AC3;
    endfunction

    bit          pa_v [LAT];
    logic [15:0] pa_a [LAT];
    always @(posedge clk) begin
        pa_v[0] <= mreq && !mwe;
        pa_a[0] <= maddr;
        for (int i = 1; i < LAT; i++) begin
            pa_v[i] <= pa_v[i-1];
            pa_a[i] <= pa_a[i-1];
        end
    end
    assign mrvalid = pa_v[LAT-1];
    assign mrdata  = pa_v[LAT-1] ? mem_img(pa_a[LAT-1]) : 16'h0000;

    bit          pb_v;
    logic [15:0] pb_a;
    always @(posedge clk) begin
        pb_v <= mreq_b && !mwe_b;
        pb_a <= maddr_b;
    end
    assign mrvalid_b = pb_v;
    assign mrdata_b  = pb_v ? mem_img(pb_a) : 16'h0000;

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ri, input logic rd, input logic wd,
                         input logic [15:0] ai, input logic [15:0] ad,
                         input logic [15:0] wa, input logic [15:0] wdat);
        rd_i   = ri;
        rd_d   = rd;
        wr_d   = wd;
        addr_i = ai;
        addr_d = ad;
        waddr  = wa;
        wdata  = wdat;
    endtask

    // Called at a negedge with the DUT idle; follows one transaction to its IDLE return.
    task automatic watch_txn(input int kind, input logic [15:0] ea, input logic [15:0] ewd,
                             input string tag);
        int          n;
        logic        own_v, oth_v;
        logic [2:0]  own_idx;
        logic [15:0] own_data;
        logic [18:0] e;
        n = 0;
        @(negedge clk);
        while (st_a == IDLE && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " grant_delay"}, 32'(n), 32'd0);
        if (st_a == IDLE) return;
        if (kind == K_WRITE) begin
            check({tag, " write_state"}, 32'(st_a), 32'(WRITE));
            check({tag, " write_req"}, 32'({mreq, mwe, maddr, mwdata}), 32'({1'b1, 1'b1, ea, ewd}));
            check({tag, " write_done_early"}, 32'(wdone), 32'd0);
            @(negedge clk);
            check({tag, " write_done"}, 32'({wdone, mreq}), 32'({1'b1, 1'b0}));
            check({tag, " write_bubble"}, 32'(st_a), 32'(DONE));
            @(negedge clk);
            check({tag, " write_idle"}, 32'({wdone, 3'(st_a)}), 32'({1'b0, 3'(IDLE)}));
        end else begin
            for (int i = 0; i < WPB; i++)
                exp_q.push_back({3'(i), mem_img(ea + 16'(2 * i))});
            for (int t = 0; t <= LAT + WPB + 2; t++) begin
                if (t > 0) @(negedge clk);
                own_v    = (kind == K_FILL_I) ? dv_i : dv_d;
                oth_v    = (kind == K_FILL_I) ? dv_d : dv_i;
                own_idx  = (kind == K_FILL_I) ? idx_i : idx_d;
                own_data = (kind == K_FILL_I) ? rdata_i : rdata_d;
                if (t < WPB)
                    check({tag, " issue"}, 32'({mreq, mwe, maddr}), 32'({1'b1, 1'b0, ea + 16'(2 * t)}));
                else
                    check({tag, " no_issue"}, 32'(mreq), 32'd0);
                check({tag, " other_valid"}, 32'(oth_v), 32'd0);
                if (t >= LAT + 1 && t <= LAT + WPB) begin
                    check({tag, " valid"}, 32'(own_v), 32'd1);
                    if (own_v && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check({tag, " word"}, 32'({own_idx, own_data}), 32'(e));
                    end
                end else begin
                    check({tag, " no_valid"}, 32'(own_v), 32'd0);
                end
                if (t == LAT + WPB + 1)
                    check({tag, " bubble"}, 32'(st_a), 32'(DONE));
            end
            check({tag, " idle"}, 32'(st_a), 32'(IDLE));
            exp_q.delete();
        end
    endtask

    // ---------------- test ----------------
    vec_t        vecs [10];
    bit          iw;
    logic        r_ri, r_rd, r_wd;
    logic [15:0] r_ai, r_ad, r_wa, r_wdat, r_ea, r_ewd;
    int          r_kind;
    int          n, seen;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0047, 16'h0000, 16'h0000, 16'h0000, K_FILL_I, 16'h0040, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0888, 16'h1234, 16'h0000, 16'h0000, K_FILL_D, 16'h1230, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0888, 16'h1456, 16'h0000, 16'h0000, K_FILL_I, 16'h0880, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0990, 16'h0000, 16'h2002, 16'hBEEF, K_WRITE,  16'h2002, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0990, 16'h0000, 16'h0000, 16'h0000, K_FILL_I, 16'h0990, 16'h0000};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0A00, 16'h0B00, 16'h2468, 16'h1357, K_WRITE,  16'h2468, 16'h1357};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, K_FILL_D, 16'h0100, 16'h0000};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0200, 16'h0000, 16'h0000, K_FILL_D, 16'h0200, 16'h0000};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, K_FILL_D, 16'hFFF0, 16'h0000};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 16'h3003, 16'h400F, 16'h0000, 16'h0000, K_FILL_D, 16'h4000, 16'h0000};

        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        rd_i_b = 1'b0; rd_d_b = 1'b0; wr_d_b = 1'b0;
        addr_i_b = 16'h0; addr_d_b = 16'h0; waddr_b = 16'h0; wdata_b = 16'h0;

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ctl_a", 32'({dv_i, dv_d, wdone, mreq, mwe, 3'(st_a)}), 32'd0);
        check("reset_bus_a", 32'({maddr, mwdata}), 32'd0);
        check("reset_rd_a", 32'({rdata_i, rdata_d}), 32'd0);
        check("reset_idx_a", 32'({idx_i, idx_d}), 32'd0);
        check("reset_ctl_b", 32'({dv_i_b, dv_d_b, wdone_b, mreq_b, mwe_b, 3'(st_b), idx_i_b, idx_d_b}), 32'd0);
        check("reset_bus_b", 32'({maddr_b, mwdata_b}), 32'd0);
        check("reset_rd_b", 32'({rdata_i_b, rdata_d_b}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: arbitration order, fill addressing, write path, back-to-back fills.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ri, vecs[i].rd, vecs[i].wd, vecs[i].ai, vecs[i].ad, vecs[i].wa, vecs[i].wdat);
            watch_txn(vecs[i].kind, vecs[i].ea, vecs[i].ewd, $sformatf("vec%0d", i));
        end

        // Reset after three returns of a D fill.
        drive(1'b0, 1'b1, 1'b0, 16'h0, 16'h0500, 16'h0, 16'h0);
        n = 0;
        seen = 0;
        while (seen < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (dv_d) seen++;
        end
        check("midfill_returns_before_reset", 32'(seen), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctl", 32'({dv_i, dv_d, wdone, mreq, mwe, 3'(st_a)}), 32'd0);
        check("async_reset_bus", 32'({maddr, mwdata}), 32'd0);
        check("async_reset_rd", 32'({rdata_i, rdata_d}), 32'd0);
        check("async_reset_idx", 32'({idx_i, idx_d}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("stale_return_ignored", 32'({dv_i, dv_d, mreq}), 32'd0);
        end
        check("post_reset_idle", 32'(st_a), 32'(IDLE));
        drive(1'b1, 1'b1, 1'b0, 16'h0710, 16'h0724, 16'h0, 16'h0);
        watch_txn(K_FILL_D, 16'h0720, 16'h0, "post_reset_both");
        drive(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0, 16'h0, 16'h0);
        watch_txn(K_FILL_I, 16'h0300, 16'h0, "post_reset_i");

        // Randomized requests against the grant-priority model.
        iw = 1'b0;
        for (int r = 0; r < 24; r++) begin
            r_ri   = 1'($urandom_range(0, 1));
            r_rd   = 1'($urandom_range(0, 1));
            r_wd   = ($urandom_range(0, 3) == 0);
            if (!r_ri && !r_rd && !r_wd) r_ri = 1'b1;
            r_ai   = 16'($urandom_range(0, 16'hFFFF));
            r_ad   = 16'($urandom_range(0, 16'hFFFF));
            r_wa   = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE;
            r_wdat = 16'($urandom_range(0, 16'hFFFF));
            r_ewd  = 16'h0;
            if (r_wd) begin
                r_kind = K_WRITE;
                r_ea   = r_wa;
                r_ewd  = r_wdat;
            end else if (r_rd && !(iw && r_ri)) begin
                r_kind = K_FILL_D;
                r_ea   = r_ad & 16'hFFF0;
                if (r_ri) iw = 1'b1;
            end else begin
                r_kind = K_FILL_I;
                r_ea   = r_ai & 16'hFFF0;
                iw     = 1'b0;
            end
            drive(r_ri, r_rd, r_wd, r_ai, r_ad, r_wa, r_wdat);
            watch_txn(r_kind, r_ea, r_ewd, $sformatf("rand%0d", r));
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Latency-1, 4-word instance.
        rd_i_b   = 1'b1;
        addr_i_b = 16'h0623;
        n = 0;
        @(negedge clk);
        while (st_b == IDLE && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b grant_delay", 32'(n), 32'd0);
        rd_i_b = 1'b0;
        for (int t = 0; t <= LAT_B + WPB_B + 2; t++) begin
            if (t > 0) @(negedge clk);
            if (t < WPB_B)
                check("b issue", 32'({mreq_b, mwe_b, maddr_b}), 32'({1'b1, 1'b0, 16'h0620 + 16'(2 * t)}));
            else
                check("b no_issue", 32'(mreq_b), 32'd0);
            check("b d_valid", 32'(dv_d_b), 32'd0);
            if (t >= LAT_B + 1 && t <= LAT_B + WPB_B) begin
                check("b valid", 32'(dv_i_b), 32'd1);
                check("b word", 32'({idx_i_b, rdata_i_b}),
                      32'({3'(t - LAT_B - 1), mem_img(16'h0620 + 16'(2 * (t - LAT_B - 1)))}));
            end else begin
                check("b no_valid", 32'(dv_i_b), 32'd0);
            end
            if (t == LAT_B + WPB_B + 1)
                check("b bubble", 32'(st_b), 32'(DONE));
        end
        check("b idle", 32'(st_b), 32'(IDLE));
        check("b write_idle", 32'({wdone_b, mwdata_b}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Memory-side responder for the phase-3 cache/memory interface. Serves the I-cache and D-cache miss and write requests (MemRead_*, mem_read_addr_*, MemWrite_D) from one shared, pipelined, fixed-latency main memory.
- Returns each block fill as a burst of MemDataValid_* pulses, one per word, and acknowledges D-cache write-through stores.
- Sits in cpu between the two cache controllers and the main memory model.

Parameters:
- MEM_LATENCY, 4, cycles from mem_req issue to the matching mem_rvalid.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (16 bytes).
- ADDR_W, 16, byte-address width.
- DATA_W, 16, word width.

Ports:
- clk  in  1  clock (rising edge)
- rst_n  in  1  asynchronous active-low reset
- MemRead_I  in  1  I-cache requests a block fill
- mem_read_addr_I  in  16  I-cache miss address (any byte in the block)
- MemDataValid_I  out  1  mem_read_data_I holds a valid fill word
- mem_read_data_I  out  16  fill word to I-cache
- mem_word_idx_I  out  3  word index of the current I fill word
- MemRead_D  in  1  D-cache requests a block fill
- mem_read_addr_D  in  16  D-cache miss address
- MemWrite_D  in  1  D-cache write-through store request
- mem_write_addr_D  in  16  store byte address (word aligned)
- mem_write_data_D  in  16  store data
- MemDataValid_D  out  1  mem_read_data_D holds a valid fill word
- mem_read_data_D  out  16  fill word to D-cache
- mem_word_idx_D  out  3  word index of the current D fill word
- mem_write_done_D  out  1  one-cycle store acknowledge
- mem_req  out  1  memory request this cycle
- mem_we  out  1  request is a write
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read return data
- mem_rvalid  in  1  read return valid; returns arrive in issue order

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; issue_cnt=0, ret_cnt=0, owner=D, i_waiting=0.
  - All outputs are 0.
- States: IDLE, WRITE, FILL, DRAIN, DONE.
- IDLE: samples requests at each edge. Grant order:
  - MemWrite_D goes to WRITE.
  - MemRead_D goes to FILL with owner=D, unless i_waiting=1 and MemRead_I=1, in which case owner=I.
  - MemRead_I goes to FILL with owner=I.
  - When both reads are pending and D wins, i_waiting is set. It clears when I is granted.
  - A D write always beats both reads.
- Block base = request address & 0xFFF0, latched at grant. The request address is ignored after grant.
- WRITE: for one cycle drive mem_req=1, mem_we=1, mem_addr=mem_write_addr_D, mem_wdata=mem_write_data_D.
  - Next cycle: mem_write_done_D=1 and state goes to DONE.
- FILL: each cycle drives mem_req=1, mem_we=0, mem_addr=base+2*issue_cnt, then issue_cnt++.
  - Goes to DRAIN after issue_cnt reaches WORDS_PER_BLOCK-1 is issued.
- FILL and DRAIN, on each mem_rvalid:
  - Next cycle (registered), MemDataValid_owner=1, mem_read_data_owner=mem_rdata, mem_word_idx_owner=ret_cnt.
  - Then ret_cnt++.
  - The non-owner's valid stays 0.
- Leave DRAIN for DONE when ret_cnt reaches WORDS_PER_BLOCK.
- Latency: grant edge k, first mem_req in cycle k+1, first MemDataValid in cycle k+1+MEM_LATENCY+1, last in cycle k+MEM_LATENCY+WORDS_PER_BLOCK+1.
- DONE: one bubble cycle so the requester can drop MemRead/MemWrite. Requests are ignored, then state returns to IDLE.
- mem_rvalid in IDLE, WRITE or DONE is ignored and drops no state. This covers stale returns after a mid-fill reset.
- Reset mid-fill: the fill aborts immediately. No further MemDataValid pulses. The cache must re-request.
- Counter widths: $clog2(WORDS_PER_BLOCK)+1 bits. Address add is modulo 2^16; the base is aligned, so there is no wrap within a block.
- mem_req is never asserted in IDLE, DRAIN or DONE.

Decomposition:
- Package cache_mem_pkg holds:
  - the state enum (IDLE, WRITE, FILL, DRAIN, DONE);
  - the owner enum (OWN_I, OWN_D);
  - BLOCK_MASK=16'hFFF0;
  - default MEM_LATENCY and WORDS_PER_BLOCK.
- One natural sub-module, fill_counter: issue and return counters with done flags, instantiated once.

Test Plan:
- I miss only, mem_read_addr_I=0x0047:
  - mem_addr goes 0x0040,0x0042,…,0x004E on 8 consecutive cycles.
  - 8 MemDataValid_I pulses with mem_word_idx_I=0..7 and data matching the memory image.
  - MemDataValid_D stays 0.
- MemRead_I and MemRead_D both asserted in the same IDLE cycle:
  - D fill (base from mem_read_addr_D=0x1234 gives 0x1230) completes first.
  - DONE bubble.
  - I fill is granted next even though a new MemRead_D is pending.
- MemWrite_D at 0x2002 with data 0xBEEF while MemRead_I is pending:
  - one mem_req with mem_we=1, addr 0x2002, data 0xBEEF.
  - mem_write_done_D pulses one cycle.
  - I fill starts after DONE.
- Back-to-back D fills at 0x0100 then 0x0200:
  - exactly 8 valid pulses per fill.
  - gap of DONE plus IDLE between bursts.
  - no address from the second block issued before the first fill's 8th return.
- rst_n dropped after 3 of 8 returns of a fill:
  - all outputs go 0 asynchronously.
  - the 5 late mem_rvalid pulses produce no MemDataValid.
  - a fresh I request at 0x0300 fills correctly.
- MEM_LATENCY=1 and WORDS_PER_BLOCK=4 override:
  - 4 returns with first MemDataValid 3 cycles after the grant edge.
  - state returns to IDLE 2 cycles after the last valid.
